decoder_2ri12_multi: RTL and testbench

//  Registered, multi-lane decode stage for LoongArch 2RI12-format instructions (inst[31:22] opcode,
//  si12/ui12 in [21:10], rj [9:5], rd [4:0]). Sits between the fetch buffer and dispatch; decodes up to

---
 rtl/decoder_2ri12_multi.sv | 207 ++++++++++++++++++++
 tb/tb_decoder_2ri12_multi.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_2ri12_multi.sv
// Registered multi-lane LoongArch 2RI12 decode stage with a 2-entry skid buffer.
// Define DECODER_2RI12_MEM_EN to also decode the LD.*/ST.* opcodes.
module decoder_2ri12_multi #(
    parameter int LANES   = 2,
    parameter int CAUSE_W = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES-1:0]           in_lane_valid,
    input  logic [LANES*32-1:0]        in_pc,
    input  logic [LANES*32-1:0]        in_inst,
    input  logic [LANES-1:0]           in_exc,
    input  logic [LANES*CAUSE_W-1:0]   in_exc_cause,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES-1:0]           out_lane_valid,
    output logic [LANES*32-1:0]        out_pc,
    output logic [LANES*32-1:0]        out_inst,
    output logic [LANES-1:0]           out_inst_valid,
    output logic [LANES-1:0]           out_exc,
    output logic [LANES*CAUSE_W-1:0]   out_exc_cause,
    output logic [LANES*8-1:0]         out_aluop,
    output logic [LANES*3-1:0]         out_alusel,
    output logic [LANES*32-1:0]        out_imm,
    output logic [LANES-1:0]           out_reg1_en,
    output logic [LANES*5-1:0]         out_reg1_addr,
    output logic [LANES-1:0]           out_reg2_en,
    output logic [LANES*5-1:0]         out_reg2_addr,
    output logic [LANES-1:0]           out_wr_en,
    output logic [LANES*5-1:0]         out_wr_addr
);

    localparam logic [7:0] ALU_NOP   = 8'h00;
    localparam logic [7:0] ALU_SLTI  = 8'h01;
    localparam logic [7:0] ALU_SLTUI = 8'h02;
    localparam logic [7:0] ALU_ADDIW = 8'h03;
    localparam logic [7:0] ALU_ANDI  = 8'h04;
    localparam logic [7:0] ALU_ORI   = 8'h05;
    localparam logic [7:0] ALU_XORI  = 8'h06;
`ifdef DECODER_2RI12_MEM_EN
    localparam logic [7:0] ALU_LDB   = 8'h07;
    localparam logic [7:0] ALU_LDH   = 8'h08;
    localparam logic [7:0] ALU_LDW   = 8'h09;
    localparam logic [7:0] ALU_LDBU  = 8'h0A;
    localparam logic [7:0] ALU_LDHU  = 8'h0B;
    localparam logic [7:0] ALU_STB   = 8'h0C;
    localparam logic [7:0] ALU_STH   = 8'h0D;
    localparam logic [7:0] ALU_STW   = 8'h0E;
`endif

    localparam logic [2:0] ALU_SEL_NOP        = 3'd0;
    localparam logic [2:0] ALU_SEL_ARITHMETIC = 3'd1;
    localparam logic [2:0] ALU_SEL_LOAD_STORE = 3'd2;

    localparam logic [CAUSE_W-1:0] EXC_INE = CAUSE_W'(13);

    typedef struct packed {
        logic [LANES-1:0]              lv;
        logic [LANES-1:0][31:0]        pc;
        logic [LANES-1:0][31:0]        inst;
        logic [LANES-1:0]              iv;
        logic [LANES-1:0]              exc;
        logic [LANES-1:0][CAUSE_W-1:0] cause;
        logic [LANES-1:0][7:0]         aluop;
        logic [LANES-1:0][2:0]         sel;
        logic [LANES-1:0][31:0]        imm;
        logic [LANES-1:0]              r1en;
        logic [LANES-1:0][4:0]         r1a;
        logic [LANES-1:0]              r2en;
        logic [LANES-1:0][4:0]         r2a;
        logic [LANES-1:0]              wen;
        logic [LANES-1:0][4:0]         wa;
    } beat_t;

    beat_t       w_beat;
    beat_t       r_main;
    beat_t       r_skid;
    logic        r_main_v;
    logic        r_skid_v;
    logic        w_acc;
    logic [31:0] w_inst;
    logic [7:0]  w_op;
    logic        w_hit;
    logic        w_sext;
    logic        w_ls;
    logic        w_st;

    always_comb begin
        w_beat = '0;
        w_inst = '0;
        w_op   = ALU_NOP;
        w_hit  = 1'b0;
        w_sext = 1'b0;
        w_ls   = 1'b0;
        w_st   = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            w_inst = in_inst[l*32 +: 32];
            w_op   = ALU_NOP;
            w_hit  = 1'b1;
            w_sext = 1'b0;
            w_ls   = 1'b0;
            w_st   = 1'b0;
            case (w_inst[31:22])
                10'h008: begin w_op = ALU_SLTI;  w_sext = 1'b1; end
                10'h009: begin w_op = ALU_SLTUI; w_sext = 1'b1; end
                10'h00A: begin w_op = ALU_ADDIW; w_sext = 1'b1; end
                10'h00D: w_op = ALU_ANDI;
                10'h00E: w_op = ALU_ORI;
                10'h00F: w_op = ALU_XORI;
`ifdef DECODER_2RI12_MEM_EN
                10'h0A0: begin w_op = ALU_LDB;  w_sext = 1'b1; w_ls = 1'b1; end
                10'h0A1: begin w_op = ALU_LDH;  w_sext = 1'b1; w_ls = 1'b1; end
                10'h0A2: begin w_op = ALU_LDW;  w_sext = 1'b1; w_ls = 1'b1; end
                10'h0A8: begin w_op = ALU_LDBU; w_sext = 1'b1; w_ls = 1'b1; end
                10'h0A9: begin w_op = ALU_LDHU; w_sext = 1'b1; w_ls = 1'b1; end
                10'h0A4: begin
                    w_op = ALU_STB; w_sext = 1'b1; w_ls = 1'b1; w_st = 1'b1;
                end
                10'h0A5: begin
                    w_op = ALU_STH; w_sext = 1'b1; w_ls = 1'b1; w_st = 1'b1;
                end
                10'h0A6: begin
                    w_op = ALU_STW; w_sext = 1'b1; w_ls = 1'b1; w_st = 1'b1;
                end
`endif
                default: w_hit = 1'b0;
            endcase

            w_beat.lv[l]   = in_lane_valid[l];
            w_beat.pc[l]   = in_pc[l*32 +: 32];
            w_beat.inst[l] = w_inst;
            // Empty lanes carry only the pass-through fields.
            if (in_lane_valid[l]) begin
                w_beat.iv[l]  = w_hit;
                w_beat.exc[l] = in_exc[l] | ~w_hit;
                if (in_exc[l])
                    w_beat.cause[l] = in_exc_cause[l*CAUSE_W +: CAUSE_W];
                else if (!w_hit)
                    w_beat.cause[l] = EXC_INE;
                if (w_hit) begin
                    w_beat.aluop[l] = w_op;
                    w_beat.sel[l]   = w_ls ? ALU_SEL_LOAD_STORE
                                           : ALU_SEL_ARITHMETIC;
                    w_beat.imm[l]   = w_sext ? {{20{w_inst[21]}}, w_inst[21:10]}
                                             : {20'b0, w_inst[21:10]};
                    w_beat.r1en[l]  = 1'b1;
                    w_beat.r1a[l]   = w_inst[9:5];
                    w_beat.r2en[l]  = w_st;
                    w_beat.r2a[l]   = w_st ? w_inst[4:0] : 5'd0;
                    w_beat.wen[l]   = ~w_st;
                    w_beat.wa[l]    = w_st ? 5'd0 : w_inst[4:0];
                end
            end
        end
    end

    assign w_acc    = in_valid & ~r_skid_v;
    assign in_ready = ~r_skid_v;

    // Skid only fills while main is stalled, so main refills from skid first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_main   <= '0;
            r_skid   <= '0;
        end else if (flush) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (!r_main_v || out_ready) begin
            if (r_skid_v) begin
                r_main   <= r_skid;
                r_main_v <= 1'b1;
                r_skid_v <= 1'b0;
            end else if (w_acc) begin
                r_main   <= w_beat;
                r_main_v <= 1'b1;
            end else begin
                r_main_v <= 1'b0;
            end
        end else if (w_acc) begin
            r_skid   <= w_beat;
            r_skid_v <= 1'b1;
        end
    end

    assign out_valid      = r_main_v;
    assign out_lane_valid = r_main.lv;
    assign out_pc         = r_main.pc;
    assign out_inst       = r_main.inst;
    assign out_inst_valid = r_main.iv;
    assign out_exc        = r_main.exc;
    assign out_exc_cause  = r_main.cause;
    assign out_aluop      = r_main.aluop;
    assign out_alusel     = r_main.sel;
    assign out_imm        = r_main.imm;
    assign out_reg1_en    = r_main.r1en;
    assign out_reg1_addr  = r_main.r1a;
    assign out_reg2_en    = r_main.r2en;
    assign out_reg2_addr  = r_main.r2a;
    assign out_wr_en      = r_main.wen;
    assign out_wr_addr    = r_main.wa;

endmodule

// File: tb/tb_decoder_2ri12_multi.sv
// Self-checking bench for decoder_2ri12_multi: directed vectors plus a
// randomized stream scored against a queue-based reference model.
module tb_decoder_2ri12_multi;

    localparam logic [7:0] ALU_NOP   = 8'h00;
    localparam logic [7:0] ALU_SLTI  = 8'h01;
    localparam logic [7:0] ALU_SLTUI = 8'h02;
    localparam logic [7:0] ALU_ADDIW = 8'h03;
    localparam logic [7:0] ALU_ANDI  = 8'h04;
    localparam logic [7:0] ALU_ORI   = 8'h05;
    localparam logic [7:0] ALU_XORI  = 8'h06;
    localparam logic [7:0] ALU_LDB   = 8'h07;
    localparam logic [7:0] ALU_LDH   = 8'h08;
    localparam logic [7:0] ALU_LDW   = 8'h09;
    localparam logic [7:0] ALU_LDBU  = 8'h0A;
    localparam logic [7:0] ALU_LDHU  = 8'h0B;
    localparam logic [7:0] ALU_STB   = 8'h0C;
    localparam logic [7:0] ALU_STH   = 8'h0D;
    localparam logic [7:0] ALU_STW   = 8'h0E;
    localparam logic [2:0] SEL_NOP   = 3'd0;
    localparam logic [2:0] SEL_ARITH = 3'd1;
    localparam logic [2:0] SEL_LS    = 3'd2;
    localparam logic [6:0] INE       = 7'h0D;

    typedef struct packed {
        logic        lv;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        iv;
        logic        exc;
        logic [6:0]  cause;
        logic [7:0]  aluop;
        logic [2:0]  sel;
        logic [31:0] imm;
        logic        r1e;
        logic [4:0]  r1a;
        logic        r2e;
        logic [4:0]  r2a;
        logic        we;
        logic [4:0]  wa;
    } lane_o_t;
    typedef lane_o_t [1:0] beat_o_t;

    typedef struct packed {
        logic [1:0]       lv;
        logic [1:0][31:0] pc;
        logic [1:0][31:0] inst;
        logic [1:0]       ex;
        logic [1:0][6:0]  cause;
    } beat_i_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_lane_valid = '0;
    logic [63:0] in_pc = '0;
    logic [63:0] in_inst = '0;
    logic [1:0]  in_exc = '0;
    logic [13:0] in_exc_cause = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_lane_valid;
    logic [63:0] out_pc;
    logic [63:0] out_inst;
    logic [1:0]  out_inst_valid;
    logic [1:0]  out_exc;
    logic [13:0] out_exc_cause;
    logic [15:0] out_aluop;
    logic [5:0]  out_alusel;
    logic [63:0] out_imm;
    logic [1:0]  out_reg1_en;
    logic [9:0]  out_reg1_addr;
    logic [1:0]  out_reg2_en;
    logic [9:0]  out_reg2_addr;
    logic [1:0]  out_wr_en;
    logic [9:0]  out_wr_addr;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    decoder_2ri12_multi #(.LANES(2), .CAUSE_W(7)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_valid(in_lane_valid), .in_pc(in_pc), .in_inst(in_inst),
        .in_exc(in_exc), .in_exc_cause(in_exc_cause),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lane_valid(out_lane_valid), .out_pc(out_pc), .out_inst(out_inst),
        .out_inst_valid(out_inst_valid), .out_exc(out_exc),
        .out_exc_cause(out_exc_cause), .out_aluop(out_aluop),
        .out_alusel(out_alusel), .out_imm(out_imm),
        .out_reg1_en(out_reg1_en), .out_reg1_addr(out_reg1_addr),
        .out_reg2_en(out_reg2_en), .out_reg2_addr(out_reg2_addr),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr)
    );

    // Reference: instruction classes straight from the opcode table.
    function automatic lane_o_t model_lane(logic lv, logic [31:0] pc,
                                           logic [31:0] inst, logic ex,
                                           logic [6:0] c);
        lane_o_t r;
        logic signed [11:0] s12;
        logic [11:0] u12;
        string cls;
        logic [7:0] op;
        r = '0;
        r.lv = lv;
        r.pc = pc;
        r.inst = inst;
        if (!lv) return r;
        s12 = inst[21:10];
        u12 = inst[21:10];
        cls = "bad";
        op = ALU_NOP;
        case (inst[31:22])
            10'h008: begin cls = "sx"; op = ALU_SLTI; end
            10'h009: begin cls = "sx"; op = ALU_SLTUI; end
            10'h00A: begin cls = "sx"; op = ALU_ADDIW; end
            10'h00D: begin cls = "zx"; op = ALU_ANDI; end
            10'h00E: begin cls = "zx"; op = ALU_ORI; end
            10'h00F: begin cls = "zx"; op = ALU_XORI; end
`ifdef DECODER_2RI12_MEM_EN
            10'h0A0: begin cls = "ld"; op = ALU_LDB; end
            10'h0A1: begin cls = "ld"; op = ALU_LDH; end
            10'h0A2: begin cls = "ld"; op = ALU_LDW; end
            10'h0A8: begin cls = "ld"; op = ALU_LDBU; end
            10'h0A9: begin cls = "ld"; op = ALU_LDHU; end
            10'h0A4: begin cls = "st"; op = ALU_STB; end
            10'h0A5: begin cls = "st"; op = ALU_STH; end
            10'h0A6: begin cls = "st"; op = ALU_STW; end
`endif
            default: cls = "bad";
        endcase
        r.exc = ex;
        r.cause = ex ? c : 7'd0;
        if (cls == "bad") begin
            r.exc = 1'b1;
            if (!ex) r.cause = INE;
            return r;
        end
        r.iv = 1'b1;
        r.aluop = op;
        r.sel = (cls == "ld" || cls == "st") ? SEL_LS : SEL_ARITH;
        r.imm = (cls == "zx") ? 32'(u12) : 32'(s12);
        r.r1e = 1'b1;
        r.r1a = inst[9:5];
        if (cls == "st") begin
            r.r2e = 1'b1;
            r.r2a = inst[4:0];
        end else begin
            r.we = 1'b1;
            r.wa = inst[4:0];
        end
        return r;
    endfunction

    function automatic beat_o_t model_beat(beat_i_t b);
        beat_o_t o;
        for (int l = 0; l < 2; l++)
            o[l] = model_lane(b.lv[l], b.pc[l], b.inst[l], b.ex[l], b.cause[l]);
        return o;
    endfunction

    function automatic beat_o_t dut_obs();
        beat_o_t o;
        for (int l = 0; l < 2; l++) begin
            o[l].lv    = out_lane_valid[l];
            o[l].pc    = out_pc[l*32 +: 32];
            o[l].inst  = out_inst[l*32 +: 32];
            o[l].iv    = out_inst_valid[l];
            o[l].exc   = out_exc[l];
            o[l].cause = out_exc_cause[l*7 +: 7];
            o[l].aluop = out_aluop[l*8 +: 8];
            o[l].sel   = out_alusel[l*3 +: 3];
            o[l].imm   = out_imm[l*32 +: 32];
            o[l].r1e   = out_reg1_en[l];
            o[l].r1a   = out_reg1_addr[l*5 +: 5];
            o[l].r2e   = out_reg2_en[l];
            o[l].r2a   = out_reg2_addr[l*5 +: 5];
            o[l].we    = out_wr_en[l];
            o[l].wa    = out_wr_addr[l*5 +: 5];
        end
        return o;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [9:0] ops [14];
        logic [31:0] r;
        int k;
        ops = '{10'h008, 10'h009, 10'h00A, 10'h00D, 10'h00E, 10'h00F,
                10'h0A0, 10'h0A1, 10'h0A2, 10'h0A8, 10'h0A9,
                10'h0A4, 10'h0A5, 10'h0A6};
        r = $urandom();
        k = $urandom_range(0, 17);
        if (k < 14) r[31:22] = ops[k];
        return r;
    endfunction

    function automatic beat_i_t gen_beat();
        beat_i_t b;
        logic [31:0] c;
        for (int l = 0; l < 2; l++) begin
            c = $urandom();
            b.lv[l] = ($urandom_range(0, 7) != 0);
            b.pc[l] = $urandom();
            b.inst[l] = gen_inst();
            b.ex[l] = ($urandom_range(0, 9) == 0);
            b.cause[l] = c[6:0];
        end
        return b;
    endfunction

    task automatic drive(beat_i_t b);
        in_lane_valid = b.lv;
        in_pc = b.pc;
        in_inst = b.inst;
        in_exc = b.ex;
        in_exc_cause = b.cause;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        beat_o_t o;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        o = dut_obs();
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1",
                     out_valid, in_ready);
        else n_pass++;
        n_chk++;
        if (o !== '0) $display("FAIL reset_data: got %h want 0", o);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic send_one(beat_i_t b, output beat_o_t o);
        drive(b);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        o = dut_obs();
        n_chk++;
        if (out_valid !== 1'b1 || o !== model_beat(b))
            $display("FAIL single_beat: valid=%b got %h want %h",
                     out_valid, o, model_beat(b));
        else n_pass++;
    endtask

    task automatic test_decode();
        beat_i_t b;
        beat_o_t o;
        do_reset();
        out_ready = 1'b1;
        b = '0;
        b.lv = 2'b11;
        b.pc = {32'h1C00_0004, 32'h1C00_0000};
        b.inst = {32'h03A00003, 32'h02BFFC41};
        send_one(b, o);
        n_chk++;
        if (o[0].imm !== 32'hFFFFFFFF || o[0].r1a !== 5'd2 ||
            o[0].wa !== 5'd1 || o[0].we !== 1'b1 ||
            o[0].aluop !== ALU_ADDIW || o[0].exc !== 1'b0)
            $display("FAIL addi_w: imm=%h r1=%0d wa=%0d op=%h exc=%b",
                     o[0].imm, o[0].r1a, o[0].wa, o[0].aluop, o[0].exc);
        else n_pass++;
        n_chk++;
        if (o[1].imm !== 32'h00000800 || o[1].r1a !== 5'd0 ||
            o[1].we !== 1'b1 || o[1].wa !== 5'd3 || o[1].aluop !== ALU_ORI)
            $display("FAIL ori_zext: imm=%h r1=%0d we=%b wa=%0d want 800/0/1/3",
                     o[1].imm, o[1].r1a, o[1].we, o[1].wa);
        else n_pass++;

        b.inst = {32'hFFFFFFFF, 32'h02800000};
        b.ex = 2'b01;
        b.cause = {7'h00, 7'h08};
        send_one(b, o);
        n_chk++;
        if (o[1].iv !== 1'b0 || o[1].exc !== 1'b1 || o[1].cause !== INE ||
            o[1].we !== 1'b0 || o[1].imm !== 32'd0)
            $display("FAIL ine_lane1: iv=%b exc=%b cause=%h want 0/1/%h",
                     o[1].iv, o[1].exc, o[1].cause, INE);
        else n_pass++;
        n_chk++;
        if (o[0].exc !== 1'b1 || o[0].cause !== 7'h08 || o[0].iv !== 1'b1)
            $display("FAIL upstream_exc: exc=%b cause=%h iv=%b want 1/08/1",
                     o[0].exc, o[0].cause, o[0].iv);
        else n_pass++;

        b.inst = {32'h29BFF0E6, 32'h288020A4};
        b.ex = 2'b00;
        send_one(b, o);
        n_chk++;
`ifdef DECODER_2RI12_MEM_EN
        if (o[0].imm !== 32'd8 || o[0].wa !== 5'd4 || o[0].we !== 1'b1 ||
            o[1].r1a !== 5'd7 || o[1].r2a !== 5'd6 || o[1].r2e !== 1'b1 ||
            o[1].we !== 1'b0 || o[1].imm !== 32'hFFFFFFFC)
            $display("FAIL ld_st: ld imm=%h wa=%0d st r1=%0d r2=%0d we=%b imm=%h",
                     o[0].imm, o[0].wa, o[1].r1a, o[1].r2a, o[1].we, o[1].imm);
        else n_pass++;
`else
        if (o[0].exc !== 1'b1 || o[0].cause !== INE ||
            o[1].exc !== 1'b1 || o[1].cause !== INE || o[0].iv !== 1'b0)
            $display("FAIL ld_st_ine: exc=%b%b cause=%h/%h want INE",
                     o[1].exc, o[0].exc, o[1].cause, o[0].cause);
        else n_pass++;
`endif

        b.lv = 2'b10;
        b.inst = {32'h02800020, 32'h02BFFC41};
        b.ex = 2'b01;
        send_one(b, o);
        n_chk++;
        if (o[0].exc !== 1'b0 || o[0].iv !== 1'b0 || o[0].we !== 1'b0 ||
            o[0].inst !== 32'h02BFFC41)
            $display("FAIL empty_lane: exc=%b iv=%b we=%b inst=%h",
                     o[0].exc, o[0].iv, o[0].we, o[0].inst);
        else n_pass++;
        n_chk++;
        if (o[1].we !== 1'b1 || o[1].wa !== 5'd0 || o[1].r1a !== 5'd1)
            $display("FAIL rd_zero: we=%b wa=%0d r1=%0d want 1/0/1",
                     o[1].we, o[1].wa, o[1].r1a);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        beat_i_t a, b, c;
        beat_o_t o;
        do_reset();
        a = gen_beat();
        b = gen_beat();
        c = gen_beat();
        in_valid = 1'b1;
        drive(a);
        @(posedge clk);
        #1 drive(b);
        @(posedge clk);
        #1 drive(c);
        @(posedge clk);
        #1;
        o = dut_obs();
        n_chk++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || o !== model_beat(a))
            $display("FAIL stall_hold: valid=%b ready=%b got %h want %h",
                     out_valid, in_ready, o, model_beat(a));
        else n_pass++;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        o = dut_obs();
        n_chk++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || o !== model_beat(b))
            $display("FAIL order_b: valid=%b ready=%b got %h want %h",
                     out_valid, in_ready, o, model_beat(b));
        else n_pass++;
        @(posedge clk);
        #1 in_valid = 1'b0;
        o = dut_obs();
        n_chk++;
        if (out_valid !== 1'b1 || o !== model_beat(c))
            $display("FAIL order_c: valid=%b got %h want %h",
                     out_valid, o, model_beat(c));
        else n_pass++;
        @(posedge clk);
        #1;
        n_chk++;
        if (out_valid !== 1'b0)
            $display("FAIL drained: out_valid=%b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_flush();
        beat_i_t f;
        beat_o_t o;
        do_reset();
        in_valid = 1'b1;
        drive(gen_beat());
        @(posedge clk);
        #1 drive(gen_beat());
        @(posedge clk);
        #1 drive(gen_beat());
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_full: valid=%b ready=%b want 0/1",
                     out_valid, in_ready);
        else n_pass++;
        in_valid = 1'b1;
        flush = 1'b1;
        drive(gen_beat());
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b0)
            $display("FAIL flush_drop: out_valid=%b want 0", out_valid);
        else n_pass++;
        out_ready = 1'b1;
        f = gen_beat();
        send_one(f, o);
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1'b1;
        drive(gen_beat());
        @(posedge clk);
        #1 drive(gen_beat());
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_obs() !== '0)
            $display("FAIL reset_mid: valid=%b ready=%b data=%h want 0/1/0",
                     out_valid, in_ready, dut_obs());
        else n_pass++;
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_random();
        beat_o_t q[$];
        beat_o_t o;
        beat_o_t e;
        beat_i_t b;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            b = gen_beat();
            drive(b);
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 39) == 0);
            @(negedge clk);
            n_chk++;
            if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2))
                $display("FAIL rand_hs[%0d]: valid=%b ready=%b model depth %0d",
                         i, out_valid, in_ready, q.size());
            else n_pass++;
            if (out_valid && out_ready && q.size() != 0) begin
                e = q.pop_front();
                o = dut_obs();
                n_chk++;
                if (o !== e)
                    $display("FAIL rand_data[%0d]: got %h want %h", i, o, e);
                else n_pass++;
            end
            if (flush) q.delete();
            else if (in_valid && in_ready) q.push_back(model_beat(b));
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
